// File: rtl/odd_seq_checker.sv
// Odd-sequence checker: monitors a counter stream expected to run
// 1, 3, 5, ..., 2^WIDTH-1, 1, ... and flags breaks once locked.
//
// Ports:
//   clk         rising-edge clock, shared with the counter
//   reset       synchronous active-low reset
//   cnt_i       sampled count value
//   valid_i     cnt_i carries a new sample this cycle
//   locked_o    high while the checker is locked to the stream
//   err_o       one-cycle pulse on a mismatch while locked
//   err_cnt_o   saturating count of err_o pulses
//   wrap_o      one-cycle pulse when a matched locked sample is all-ones
//   expected_o  next value the checker expects
module odd_seq_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             valid_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] expected_o
);

  // LOCK_COUNT is at most 15, so four bits always suffice.
  localparam int unsigned MC_W = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic [MC_W-1:0]   match_cnt_q, match_cnt_d;
  logic [WIDTH-1:0]  expected_q,  expected_d;
  logic              locked_q,    locked_d;
  logic              err_q,       err_d;
  logic              wrap_q,      wrap_d;
  logic [ERR_W-1:0]  err_cnt_q,   err_cnt_d;

  logic              is_odd_c;
  logic              is_match_c;
  logic [WIDTH-1:0]  next_exp_c;
  logic [MC_W-1:0]   mc_inc_c;

  assign is_odd_c   = cnt_i[0];
  assign is_match_c = (cnt_i == expected_q);
  // Modulo add: all-ones + 2 wraps naturally to 1.
  assign next_exp_c = cnt_i + WIDTH'(2);
  assign mc_inc_c   = match_cnt_q + MC_W'(1);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SEARCH;
      match_cnt_q <= '0;
      expected_q  <= WIDTH'(1);
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      expected_q  <= expected_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    expected_d  = expected_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    wrap_d      = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (valid_i) begin
      unique case (state_q)
        SEARCH: begin
          if (is_odd_c) begin
            state_d     = ACQUIRE;
            match_cnt_d = MC_W'(1);
            expected_d  = next_exp_c;
          end
        end

        ACQUIRE: begin
          if (is_match_c) begin
            match_cnt_d = mc_inc_c;
            expected_d  = next_exp_c;
            if (mc_inc_c == MC_W'(LOCK_COUNT)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else if (is_odd_c) begin
            // Restart acquisition from this sample.
            match_cnt_d = MC_W'(1);
            expected_d  = next_exp_c;
          end else begin
            state_d     = SEARCH;
            match_cnt_d = '0;
            expected_d  = WIDTH'(1);
          end
        end

        LOCKED: begin
          if (is_match_c) begin
            expected_d = next_exp_c;
            wrap_d     = (cnt_i == {WIDTH{1'b1}});
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (is_odd_c) begin
              state_d     = ACQUIRE;
              match_cnt_d = MC_W'(1);
              expected_d  = next_exp_c;
            end else begin
              state_d     = SEARCH;
              match_cnt_d = '0;
              expected_d  = WIDTH'(1);
            end
          end
        end

        default: begin
          state_d     = SEARCH;
          match_cnt_d = '0;
          expected_d  = WIDTH'(1);
          locked_d    = 1'b0;
        end
      endcase
    end
  end

  assign locked_o   = locked_q;
  assign err_o      = err_q;
  assign err_cnt_o  = err_cnt_q;
  assign wrap_o     = wrap_q;
  assign expected_o = expected_q;

endmodule

// File: doc/odd_seq_checker.md
Name: odd_seq_checker

Overview:
- Receive-side companion to the odd counter: samples the counter's 8-bit output stream and checks that it follows the odd sequence 1, 3, 5, …, 255, 1, ….
- Acquires lock after a run of consecutive correct samples, then flags every break in the sequence.
- Keeps a saturating error count and pulses on each wrap.
- Sits beside the counter in the same clock domain as a self-checking monitor usable in silicon and in benches.

Parameters:
- WIDTH, 8, width of sampled count value.
- LOCK_COUNT, 4, consecutive correct samples (including the first) needed to enter LOCKED; legal range 2..15.
- ERR_W, 16, width of saturating error counter.

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- cnt_i  input  WIDTH  count value under check.
- valid_i  input  1  cnt_i is a new sample this cycle; when low the checker holds all state.
- locked_o  output  1  high while in LOCKED.
- err_o  output  1  one-cycle pulse: a sample mismatched while LOCKED.
- err_cnt_o  output  ERR_W  number of err_o pulses since reset, saturates at all-ones.
- wrap_o  output  1  one-cycle pulse: matched sample equal to 2^WIDTH-1 while LOCKED.
- expected_o  output  WIDTH  next value the checker expects.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous, active-low: when reset==0 at a rising edge, next-state is state=SEARCH, match_cnt=0, expected_o=1, locked_o=0, err_o=0, wrap_o=0, err_cnt_o=0.
  - Reset overrides valid_i. Reset asserted mid-operation, including mid-LOCKED, behaves identically: err_cnt_o clears.
- Timing:
  - All outputs are registered.
  - A sample accepted at edge N is reflected in outputs after edge N (visible during cycle N+1).
  - err_o and wrap_o are high for exactly one cycle per event.
- Arithmetic: expected next = sample + 2 modulo 2^WIDTH. This gives 2^WIDTH-1 -> 1 with no special case.
- Odd test: cnt_i[0]==1.
- State machine (transitions only on valid_i==1):
  - SEARCH:
    - Odd sample: expected_o=sample+2, match_cnt=1, go ACQUIRE.
    - Even sample: stay, no error.
  - ACQUIRE:
    - sample==expected_o: match_cnt+1, expected_o+=2. When match_cnt reaches LOCK_COUNT, go LOCKED and set locked_o=1 on the same edge.
    - Mismatch with odd sample: restart, match_cnt=1, expected_o=sample+2, stay ACQUIRE.
    - Mismatch with even sample: go SEARCH, match_cnt=0, expected_o=1.
    - No error is ever flagged in ACQUIRE.
  - LOCKED:
    - Match: expected_o+=2, stay. wrap_o=1 if sample==2^WIDTH-1.
    - Mismatch: err_o=1, err_cnt_o+=1 (hold at all-ones), locked_o=0.
    - After a mismatch with an odd sample, go ACQUIRE with match_cnt=1, expected_o=sample+2.
    - After a mismatch with an even sample, go SEARCH with expected_o=1.
- valid_i==0: no state change; err_o and wrap_o are 0 that cycle.
- Repeated sample (counter stalled with valid_i high) counts as a mismatch.
- Simultaneous events:
  - A mismatch never asserts wrap_o.
  - Reset in the same cycle as a mismatch: reset wins, no err_o.

Test Plan:
- Reset held low 2 cycles, then feed 1,3,5,7 with valid_i=1 -> locked_o rises after 4th sample; err_o never high; expected_o=9.
- Locked stream continues 249,251,253,255,1,3 -> wrap_o single pulse the cycle after 255 is sampled; locked_o stays 1; expected_o=5 at end.
- Locked at expected 21, feed 25 -> err_o pulse, err_cnt_o=1, locked_o=0, state ACQUIRE, expected_o=27. Then 27,29,31 -> relock (4 samples total).
- Start from reset, feed 4,6,7,9,12 -> no err_o. State goes SEARCH->SEARCH->ACQUIRE->ACQUIRE->SEARCH; expected_o=1.
- Locked, valid_i low for 5 cycles with cnt_i random -> outputs unchanged. Resume with the correct value -> no error.
- ERR_W=2 override: force 5 locked mismatches (relocking between) -> err_cnt_o saturates at 3. Assert reset while locked -> locked_o=0 and err_cnt_o=0 after the edge.
